xgs_trig_ctrl: RTL

XGS_TRIG_CTRL -- requirements
Module: xgs_trig_ctrl

---
 rtl/xgs_athena_pkg.sv | 24 ++
 rtl/xgs_trig_filter.sv | 48 ++++
 rtl/xgs_trig_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/xgs_athena_pkg.sv
// Shared encodings for the XGS trigger controller: FSM states, grab
// sources and hardware trigger activation modes.
package xgs_athena_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_DELAY   = 3'd2,
        ST_FIRE    = 3'd3,
        ST_WAIT_RO = 3'd4
    } ctrl_state_t;

    localparam logic [2:0] SRC_IMMEDIATE = 3'd1;
    localparam logic [2:0] SRC_HW_TRIG   = 3'd2;
    localparam logic [2:0] SRC_SW_TRIG   = 3'd3;
    localparam logic [2:0] SRC_SFNC      = 3'd4;

    localparam logic [2:0] ACT_RISING    = 3'd0;
    localparam logic [2:0] ACT_FALLING   = 3'd1;
    localparam logic [2:0] ACT_ANY       = 3'd2;
    localparam logic [2:0] ACT_LEVEL_HI  = 3'd3;
    localparam logic [2:0] ACT_LEVEL_LO  = 3'd4;

endpackage

// File: rtl/xgs_trig_filter.sv
// External trigger conditioning: 2-flop synchronizer, glitch filter that
// needs filter_len+1 consecutive differing samples, and edge detection.
module xgs_trig_filter #(
    parameter int FILT_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              trig_in,
    input  logic [FILT_W-1:0] filter_len,
    output logic              level,
    output logic              rise,
    output logic              fall
);

    logic [1:0]        sync_reg;
    logic              filt_reg;
    logic              filt_d_reg;
    logic [FILT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_reg   <= '0;
            filt_reg   <= 1'b0;
            filt_d_reg <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            sync_reg   <= {sync_reg[0], trig_in};
            filt_d_reg <= filt_reg;
            // cnt_reg holds how many differing samples were already seen
            if (sync_reg[1] != filt_reg) begin
                if (cnt_reg == filter_len) begin
                    filt_reg <= sync_reg[1];
                    cnt_reg  <= '0;
                end else begin
                    cnt_reg  <= cnt_reg + 1'b1;
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    // Edges are combinational off the filter registers to keep latency minimal.
    assign level = filt_reg;
    assign rise  = filt_reg & ~filt_d_reg;
    assign fall  = ~filt_reg & filt_d_reg;

endmodule

// File: rtl/xgs_trig_ctrl.sv
// Grab/trigger sequencer for the XGS sensor: event qualification, trigger
// delay, sensor handshake, frame counting and missed-trigger statistics.
module xgs_trig_ctrl
    import xgs_athena_pkg::*;
#(
    parameter int DLY_W  = 24,
    parameter int FILT_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              sys_clk,
    input  logic              sys_reset_n,
    input  logic              grab_arm,
    input  logic              grab_abort,
    input  logic [2:0]        grab_source,
    input  logic [2:0]        grab_activation,
    input  logic [CNT_W-1:0]  grab_count,
    input  logic [DLY_W-1:0]  trig_delay,
    input  logic [FILT_W-1:0] filter_len,
    input  logic              hw_trig_in,
    input  logic              sw_trig,
    input  logic              sensor_ready,
    input  logic              readout_done,
    output logic              sensor_trig,
    output logic              grab_active,
    output logic              grab_done,
    output logic [CNT_W-1:0]  trig_missed_cnt,
    output logic [2:0]        ctrl_state
);

    logic hw_level, hw_rise, hw_fall;
    logic hw_evt, hw_edge_evt, trig_evt, missable_evt;

    ctrl_state_t       state_reg;
    logic [DLY_W-1:0]  dly_cnt_reg;
    logic [CNT_W-1:0]  frames_left_reg;
    logic [CNT_W-1:0]  missed_cnt_reg;
    logic              sensor_trig_reg;
    logic              grab_done_reg;

    xgs_trig_filter #(
        .FILT_W (FILT_W)
    ) u_filter (
        .clk        (sys_clk),
        .reset_n    (sys_reset_n),
        .trig_in    (hw_trig_in),
        .filter_len (filter_len),
        .level      (hw_level),
        .rise       (hw_rise),
        .fall       (hw_fall)
    );

    // Level-qualified events never count as missed; only discrete events do.
    always_comb begin
        hw_evt      = 1'b0;
        hw_edge_evt = 1'b0;
        case (grab_activation)
            ACT_RISING:   begin hw_evt = hw_rise;           hw_edge_evt = hw_rise;           end
            ACT_FALLING:  begin hw_evt = hw_fall;           hw_edge_evt = hw_fall;           end
            ACT_ANY:      begin hw_evt = hw_rise | hw_fall; hw_edge_evt = hw_rise | hw_fall; end
            ACT_LEVEL_HI: hw_evt = hw_level;
            ACT_LEVEL_LO: hw_evt = ~hw_level;
            default:      ;
        endcase

        trig_evt     = 1'b0;
        missable_evt = 1'b0;
        case (grab_source)
            SRC_IMMEDIATE: trig_evt = 1'b1;
            SRC_HW_TRIG:   begin trig_evt = hw_evt;           missable_evt = hw_edge_evt;           end
            SRC_SW_TRIG:   begin trig_evt = sw_trig;          missable_evt = sw_trig;               end
            SRC_SFNC:      begin trig_evt = hw_evt | sw_trig; missable_evt = hw_edge_evt | sw_trig; end
            default:       ;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_reset_n) begin
            state_reg       <= ST_IDLE;
            dly_cnt_reg     <= '0;
            frames_left_reg <= '0;
            missed_cnt_reg  <= '0;
            sensor_trig_reg <= 1'b0;
            grab_done_reg   <= 1'b0;
        end else begin
            sensor_trig_reg <= 1'b0;
            grab_done_reg   <= 1'b0;

            if (missable_evt && missed_cnt_reg != '1 &&
                (state_reg == ST_DELAY || state_reg == ST_FIRE || state_reg == ST_WAIT_RO))
                missed_cnt_reg <= missed_cnt_reg + 1'b1;

            if (grab_abort) begin
                state_reg <= ST_IDLE;
            end else begin
                case (state_reg)
                    ST_IDLE: if (grab_arm) begin
                        state_reg       <= ST_ARMED;
                        frames_left_reg <= grab_count;
                        missed_cnt_reg  <= '0;
                    end
                    ST_ARMED: if (trig_evt) begin
                        if (trig_delay == '0) begin
                            state_reg <= ST_FIRE;
                        end else begin
                            state_reg   <= ST_DELAY;
                            dly_cnt_reg <= trig_delay;
                        end
                    end
                    ST_DELAY: begin
                        dly_cnt_reg <= dly_cnt_reg - 1'b1;
                        if (dly_cnt_reg == DLY_W'(1))
                            state_reg <= ST_FIRE;
                    end
                    ST_FIRE: if (sensor_ready) begin
                        sensor_trig_reg <= 1'b1;
                        state_reg       <= ST_WAIT_RO;
                    end
                    ST_WAIT_RO: if (readout_done) begin
                        // frames_left stays 0 only for a continuous grab
                        if (frames_left_reg == '0) begin
                            state_reg <= ST_ARMED;
                        end else begin
                            frames_left_reg <= frames_left_reg - 1'b1;
                            if (frames_left_reg == CNT_W'(1)) begin
                                state_reg     <= ST_IDLE;
                                grab_done_reg <= 1'b1;
                            end else begin
                                state_reg <= ST_ARMED;
                            end
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign sensor_trig     = sensor_trig_reg;
    assign grab_done       = grab_done_reg;
    assign grab_active     = (state_reg != ST_IDLE);
    assign trig_missed_cnt = missed_cnt_reg;
    assign ctrl_state      = state_reg;

endmodule
